// File: rtl/mem_lsu_sb_pkg.sv
// Shared op/exception encodings and helpers for the MEM-stage load/store unit.
package mem_lsu_sb_pkg;

  localparam int DATA_WIDTH_ISA_EXP = 4;

  localparam logic [3:0] MEM_OP_LB   = 4'h0;
  localparam logic [3:0] MEM_OP_LH   = 4'h1;
  localparam logic [3:0] MEM_OP_LW   = 4'h2;
  localparam logic [3:0] MEM_OP_LD   = 4'h3;
  localparam logic [3:0] MEM_OP_LBU  = 4'h4;
  localparam logic [3:0] MEM_OP_LHU  = 4'h5;
  localparam logic [3:0] MEM_OP_LWU  = 4'h6;
  localparam logic [3:0] MEM_OP_SB   = 4'h8;
  localparam logic [3:0] MEM_OP_SH   = 4'h9;
  localparam logic [3:0] MEM_OP_SW   = 4'hA;
  localparam logic [3:0] MEM_OP_SD   = 4'hB;
  localparam logic [3:0] MEM_OP_NONE = 4'hF;

  localparam logic [DATA_WIDTH_ISA_EXP-1:0] ISA_EXP_NO_EXP           = 4'd0;
  localparam logic [DATA_WIDTH_ISA_EXP-1:0] ISA_EXP_LOAD_MISALIGNED  = 4'd4;
  localparam logic [DATA_WIDTH_ISA_EXP-1:0] ISA_EXP_STORE_MISALIGNED = 4'd6;

  typedef enum logic [1:0] {LSU_IDLE, LSU_LD_REQ, LSU_LD_WAIT} lsu_state_e;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       uns;
    logic [1:0] sz;   // log2 of access size in bytes
  } mem_dec_t;

  function automatic logic [7:0] size_be_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_be_mask = 8'h01;
      2'd1:    size_be_mask = 8'h03;
      2'd2:    size_be_mask = 8'h0F;
      default: size_be_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_sb_store_buffer.sv
// Circular store buffer with a byte-granular youngest-match forward lookup.
module lsu_store_buffer
  import mem_lsu_sb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4,
  localparam int NB      = XLEN / 8,
  localparam int PTR_W   = $clog2(SB_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [NB-1:0]     push_be_i,
  input  logic [XLEN-1:0]   push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [NB-1:0]     head_be_o,
  output logic [XLEN-1:0]   head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  input  logic [ADDR_W-1:0] lk_addr_i,
  output logic [NB-1:0]     lk_hit_be_o,
  output logic [XLEN-1:0]   lk_data_o
);

  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [NB-1:0]     be_q   [SB_DEPTH];
  logic [XLEN-1:0]   data_q [SB_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, idx;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PTR_W'(1);
      if (pop_i)  head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      be_q[tail_q]   <= push_be_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // Walk oldest to youngest so later matches overwrite earlier ones per byte.
  always_comb begin
    lk_hit_be_o = '0;
    lk_data_o   = '0;
    idx         = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == lk_addr_i)) begin
        for (int b = 0; b < NB; b++) begin
          if (be_q[idx][b]) begin
            lk_hit_be_o[b]      = 1'b1;
            lk_data_o[8*b +: 8] = data_q[idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign head_addr_o = addr_q[head_q];
  assign head_be_o   = be_q[head_q];
  assign head_data_o = data_q[head_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(SB_DEPTH));

endmodule

// File: rtl/mem_lsu_sb.sv
// MEM-stage load/store unit: store buffer drain, store-to-load forwarding, load FSM.
module mem_lsu_sb
  import mem_lsu_sb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  output logic                          ex_ready,
  input  logic [3:0]                    ex_mem_op,
  input  logic [ADDR_W-1:0]             ex_addr,
  input  logic [XLEN-1:0]               ex_wdata,
  output logic                          ld_valid,
  output logic [XLEN-1:0]               ld_data,
  output logic                          exp_valid,
  output logic [DATA_WIDTH_ISA_EXP-1:0] exp_code,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [XLEN/8-1:0]             mem_be,
  output logic [XLEN-1:0]               mem_wdata,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [XLEN-1:0]               mem_rdata,
  output logic                          sb_empty
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  lsu_state_e state_q, state_d;
  mem_dec_t   dec;
  logic mis, acc, ld_acc, ld_fwd, ld_mem, st_push, drain_req, pop, rsp, fwd_full, fwd_any;
  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] waddr, hd_addr;
  logic [NB-1:0]     need_be, hit_be, hd_be;
  logic [XLEN-1:0]   st_data, fwd_data, hd_data;
  logic [CNT_W-1:0]  count;
  logic              full;

  logic              ld_valid_q, exp_valid_q, drain_hold_q, sb_empty_q;
  logic [XLEN-1:0]   ld_data_q;
  logic [DATA_WIDTH_ISA_EXP-1:0] exp_code_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [OFF_W-1:0]  ld_off_q;
  logic [1:0]        ld_sz_q;
  logic              ld_uns_q;

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w, input logic [OFF_W-1:0] o,
                                              input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] s;
    s = w >> {o, 3'b000};
    case (sz)
      2'd0:    extract = uns ? XLEN'(s[7:0])  : XLEN'($signed(s[7:0]));
      2'd1:    extract = uns ? XLEN'(s[15:0]) : XLEN'($signed(s[15:0]));
      2'd2:    extract = uns ? XLEN'(s[31:0]) : XLEN'($signed(s[31:0]));
      default: extract = s;
    endcase
  endfunction

  // 64-bit-only ops fall through to the no-op decode on a 32-bit build.
  always_comb begin
    dec = '0;
    case (ex_mem_op)
      MEM_OP_LB:  begin dec.ld = 1'b1; dec.sz = 2'd0; end
      MEM_OP_LH:  begin dec.ld = 1'b1; dec.sz = 2'd1; end
      MEM_OP_LW:  begin dec.ld = 1'b1; dec.sz = 2'd2; end
      MEM_OP_LBU: begin dec.ld = 1'b1; dec.sz = 2'd0; dec.uns = 1'b1; end
      MEM_OP_LHU: begin dec.ld = 1'b1; dec.sz = 2'd1; dec.uns = 1'b1; end
      MEM_OP_LWU: if (XLEN == 64) begin dec.ld = 1'b1; dec.sz = 2'd2; dec.uns = 1'b1; end
      MEM_OP_LD:  if (XLEN == 64) begin dec.ld = 1'b1; dec.sz = 2'd3; end
      MEM_OP_SB:  begin dec.st = 1'b1; dec.sz = 2'd0; end
      MEM_OP_SH:  begin dec.st = 1'b1; dec.sz = 2'd1; end
      MEM_OP_SW:  begin dec.st = 1'b1; dec.sz = 2'd2; end
      MEM_OP_SD:  if (XLEN == 64) begin dec.st = 1'b1; dec.sz = 2'd3; end
      default: ;
    endcase
  end

  assign mis      = (dec.ld | dec.st) & |(ex_addr[2:0] & ((3'd1 << dec.sz) - 3'd1));
  assign off      = ex_addr[OFF_W-1:0];
  assign waddr    = {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign need_be  = NB'(size_be_mask(dec.sz)) << off;
  assign st_data  = ex_wdata << {off, 3'b000};
  assign fwd_full = ((hit_be & need_be) == need_be);
  assign fwd_any  = |(hit_be & need_be);

  // A load needing the bus waits while an ungranted drain request is pending.
  always_comb begin
    ex_ready = 1'b0;
    if (state_q == LSU_IDLE) begin
      if (mis || !(dec.ld || dec.st)) ex_ready = 1'b1;
      else if (dec.st)                ex_ready = !full;
      else if (fwd_full)              ex_ready = 1'b1;
      else if (fwd_any)               ex_ready = 1'b0;
      else                            ex_ready = !drain_hold_q;
    end
  end

  assign acc       = ex_valid & ex_ready;
  assign ld_acc    = acc & dec.ld & !mis;
  assign ld_fwd    = ld_acc & fwd_full;
  assign ld_mem    = ld_acc & !fwd_full;
  assign st_push   = acc & dec.st & !mis;
  assign drain_req = (state_q == LSU_IDLE) && (count != '0) && (drain_hold_q || !ld_acc);
  assign pop       = drain_req & mem_gnt;
  assign rsp       = (state_q == LSU_LD_WAIT) & mem_rvalid;

  lsu_store_buffer #(.XLEN(XLEN), .ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) u_sb (
    .clk, .rst_n,
    .push_i(st_push), .push_addr_i(waddr), .push_be_i(need_be), .push_data_i(st_data),
    .pop_i(pop), .head_addr_o(hd_addr), .head_be_o(hd_be), .head_data_o(hd_data),
    .count_o(count), .full_o(full),
    .lk_addr_i(waddr), .lk_hit_be_o(hit_be), .lk_data_o(fwd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:    if (ld_mem)     state_d = LSU_LD_REQ;
      LSU_LD_REQ:  if (mem_gnt)    state_d = LSU_LD_WAIT;
      LSU_LD_WAIT: if (mem_rvalid) state_d = LSU_IDLE;
      default:                     state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == LSU_LD_REQ) begin
      mem_req  = 1'b1;
      mem_addr = ld_addr_q;
      mem_be   = '1;
    end else if (drain_req) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = hd_addr;
      mem_be    = hd_be;
      mem_wdata = hd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid_q   <= 1'b0;
      ld_data_q    <= '0;
      exp_valid_q  <= 1'b0;
      exp_code_q   <= ISA_EXP_NO_EXP;
      drain_hold_q <= 1'b0;
      sb_empty_q   <= 1'b1;
      ld_addr_q    <= '0;
      ld_off_q     <= '0;
      ld_sz_q      <= '0;
      ld_uns_q     <= 1'b0;
    end else begin
      ld_valid_q   <= ld_fwd | rsp;
      if (ld_fwd)   ld_data_q <= extract(fwd_data, off, dec.sz, dec.uns);
      else if (rsp) ld_data_q <= extract(mem_rdata, ld_off_q, ld_sz_q, ld_uns_q);
      exp_valid_q  <= acc & mis;
      exp_code_q   <= !(acc & mis) ? ISA_EXP_NO_EXP :
                      dec.ld ? ISA_EXP_LOAD_MISALIGNED : ISA_EXP_STORE_MISALIGNED;
      drain_hold_q <= drain_req & !mem_gnt;
      sb_empty_q   <= ((count + CNT_W'(st_push) - CNT_W'(pop)) == '0);
      if (ld_mem) begin
        ld_addr_q <= waddr;
        ld_off_q  <= off;
        ld_sz_q   <= dec.sz;
        ld_uns_q  <= dec.uns;
      end
    end
  end

  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign exp_valid = exp_valid_q;
  assign exp_code  = exp_code_q;
  assign sb_empty  = sb_empty_q;

endmodule

// File: tb/tb_mem_lsu_sb.sv
// Directed per-cycle vector bench for mem_lsu_sb (XLEN=32, SB_DEPTH=4).
module tb_mem_lsu_sb;
  import mem_lsu_sb_pkg::*;

  localparam logic [3:0] N  = MEM_OP_NONE;
  localparam logic [3:0] NX = ISA_EXP_NO_EXP;
  localparam logic [3:0] LM = ISA_EXP_LOAD_MISALIGNED;
  localparam logic [3:0] SM = ISA_EXP_STORE_MISALIGNED;

  logic        clk, rst_n;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_addr, ex_wdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        exp_valid;
  logic [3:0]  exp_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        sb_empty;

  int nchk = 0;
  int nerr = 0;

  mem_lsu_sb #(.XLEN(32), .ADDR_W(32), .SB_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ld_valid(ld_valid), .ld_data(ld_data),
    .exp_valid(exp_valid), .exp_code(exp_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic vld; logic [3:0] op; logic [31:0] addr, wdata;
    logic gnt, rv; logic [31:0] rdata;
    logic rdy, req, we; logic [3:0] be; logic [31:0] maddr, mwd;
    logic ldv; logic [31:0] ldd; logic expv; logic [3:0] expc; logic empty;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int vld, input logic [3:0] op, input logic [31:0] addr, wdata,
                     input int gnt, rv, input logic [31:0] rdata,
                     input int rdy, req, we, be, input logic [31:0] maddr, mwd,
                     input int ldv, input logic [31:0] ldd, input int expv,
                     input logic [3:0] expc, input int empty);
    vec_t v;
    v.vld = 1'(vld); v.op = op; v.addr = addr; v.wdata = wdata;
    v.gnt = 1'(gnt); v.rv = 1'(rv); v.rdata = rdata;
    v.rdy = 1'(rdy); v.req = 1'(req); v.we = 1'(we); v.be = 4'(be);
    v.maddr = maddr; v.mwd = mwd; v.ldv = 1'(ldv); v.ldd = ldd;
    v.expv = 1'(expv); v.expc = expc; v.empty = 1'(empty);
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] op, input logic [31:0] addr, wdata,
                       input logic gnt, rv, input logic [31:0] rdata);
    ex_valid = vld; ex_mem_op = op; ex_addr = addr; ex_wdata = wdata;
    mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rdata;
  endtask

  task automatic chk_reset(input int row);
    chk("rst_ex_ready", row, 32'(ex_ready), 32'h1);
    chk("rst_ld_valid", row, 32'(ld_valid), 32'h0);
    chk("rst_ld_data", row, ld_data, 32'h0);
    chk("rst_exp_valid", row, 32'(exp_valid), 32'h0);
    chk("rst_exp_code", row, 32'(exp_code), 32'(NX));
    chk("rst_mem_req", row, 32'(mem_req), 32'h0);
    chk("rst_mem_we", row, 32'(mem_we), 32'h0);
    chk("rst_mem_addr", row, mem_addr, 32'h0);
    chk("rst_mem_be", row, 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", row, mem_wdata, 32'h0);
    chk("rst_sb_empty", row, 32'(sb_empty), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, N, 0, 0, 1'b0, 1'b0, 0);

    // vld op addr wdata | gnt rv rdata | rdy req we be maddr mwd | ldv ldd expv expc empty
    // SW then LW: full forward, drain afterwards
    add(1, MEM_OP_SW, 'h1000, 'hDEADBEEF, 0,0,0, 1,0,0,0,0,0, 0,'h0,0,NX,1);
    add(1, MEM_OP_LW, 'h1000, 0,          0,0,0, 1,0,0,0,0,0, 0,'h0,0,NX,0);
    add(0, N, 0, 0,                       1,0,0, 1,1,1,'hF,'h1000,'hDEADBEEF, 1,'hDEADBEEF,0,NX,0);
    add(0, N, 0, 0,                       0,0,0, 1,0,0,0,0,0, 0,'hDEADBEEF,0,NX,1);
    // SB then LB / LBU forwarded
    add(1, MEM_OP_SB, 'h2001, 'h80,       0,0,0, 1,0,0,0,0,0, 0,'hDEADBEEF,0,NX,1);
    add(1, MEM_OP_LB, 'h2001, 0,          0,0,0, 1,0,0,0,0,0, 0,'hDEADBEEF,0,NX,0);
    add(1, MEM_OP_LBU,'h2001, 0,          0,0,0, 1,0,0,0,0,0, 1,'hFFFFFF80,0,NX,0);
    add(0, N, 0, 0,                       1,0,0, 1,1,1,'h2,'h2000,'h8000, 1,'h80,0,NX,0);
    add(0, N, 0, 0,                       0,0,0, 1,0,0,0,0,0, 0,'h80,0,NX,1);
    // SB then LW partial overlap: stall until drained, then memory read
    add(1, MEM_OP_SB, 'h3000, 'h11,       0,0,0, 1,0,0,0,0,0, 0,'h80,0,NX,1);
    add(1, MEM_OP_LW, 'h3000, 0,          0,0,0, 0,1,1,'h1,'h3000,'h11, 0,'h80,0,NX,0);
    add(1, MEM_OP_LW, 'h3000, 0,          0,0,0, 0,1,1,'h1,'h3000,'h11, 0,'h80,0,NX,0);
    add(1, MEM_OP_LW, 'h3000, 0,          1,0,0, 0,1,1,'h1,'h3000,'h11, 0,'h80,0,NX,0);
    add(1, MEM_OP_LW, 'h3000, 0,          0,0,0, 1,0,0,0,0,0, 0,'h80,0,NX,1);
    add(0, N, 0, 0,                       0,0,0, 0,1,0,'hF,'h3000,0, 0,'h80,0,NX,1);
    add(0, N, 0, 0,                       1,0,0, 0,1,0,'hF,'h3000,0, 0,'h80,0,NX,1);
    add(0, N, 0, 0,                       0,1,'hCAFEF00D, 0,0,0,0,0,0, 0,'h80,0,NX,1);
    add(0, N, 0, 0,                       0,0,0, 1,0,0,0,0,0, 1,'hCAFEF00D,0,NX,1);
    // misaligned load / store
    add(1, MEM_OP_LH, 'h4003, 0,          0,0,0, 1,0,0,0,0,0, 0,'hCAFEF00D,0,NX,1);
    add(1, MEM_OP_SW, 'h4002, 'h1234,     0,0,0, 1,0,0,0,0,0, 0,'hCAFEF00D,1,LM,1);
    add(0, N, 0, 0,                       0,0,0, 1,0,0,0,0,0, 0,'hCAFEF00D,1,SM,1);
    add(0, N, 0, 0,                       0,0,0, 1,0,0,0,0,0, 0,'hCAFEF00D,0,NX,1);
    // LH from memory at offset 2, sign-extended
    add(1, MEM_OP_LH, 'h5002, 0,          0,0,0, 1,0,0,0,0,0, 0,'hCAFEF00D,0,NX,1);
    add(0, N, 0, 0,                       1,0,0, 0,1,0,'hF,'h5000,0, 0,'hCAFEF00D,0,NX,1);
    add(0, N, 0, 0,                       0,1,'h80011234, 0,0,0,0,0,0, 0,'hCAFEF00D,0,NX,1);
    add(0, N, 0, 0,                       0,0,0, 1,0,0,0,0,0, 1,'hFFFF8001,0,NX,1);
    // fill the buffer with no grant, 5th store stalls, one grant frees a slot
    add(1, MEM_OP_SW, 'h7000, 'h1,        0,0,0, 1,0,0,0,0,0, 0,'hFFFF8001,0,NX,1);
    add(1, MEM_OP_SH, 'h7006, 'hABCD,     0,0,0, 1,1,1,'hF,'h7000,'h1, 0,'hFFFF8001,0,NX,0);
    add(1, MEM_OP_SB, 'h7008, 'h5A,       0,0,0, 1,1,1,'hF,'h7000,'h1, 0,'hFFFF8001,0,NX,0);
    add(1, MEM_OP_SW, 'h700C, 'h3,        0,0,0, 1,1,1,'hF,'h7000,'h1, 0,'hFFFF8001,0,NX,0);
    add(1, MEM_OP_SW, 'h7010, 'h5,        0,0,0, 0,1,1,'hF,'h7000,'h1, 0,'hFFFF8001,0,NX,0);
    add(1, MEM_OP_SW, 'h7010, 'h5,        1,0,0, 0,1,1,'hF,'h7000,'h1, 0,'hFFFF8001,0,NX,0);
    add(1, MEM_OP_SW, 'h7010, 'h5,        0,0,0, 1,1,1,'hC,'h7004,'hABCD0000, 0,'hFFFF8001,0,NX,0);
    add(0, N, 0, 0,                       1,0,0, 1,1,1,'hC,'h7004,'hABCD0000, 0,'hFFFF8001,0,NX,0);
    add(0, N, 0, 0,                       1,0,0, 1,1,1,'h1,'h7008,'h5A, 0,'hFFFF8001,0,NX,0);
    add(0, N, 0, 0,                       1,0,0, 1,1,1,'hF,'h700C,'h3, 0,'hFFFF8001,0,NX,0);
    add(0, N, 0, 0,                       1,0,0, 1,1,1,'hF,'h7010,'h5, 0,'hFFFF8001,0,NX,0);
    add(0, N, 0, 0,                       0,0,0, 1,0,0,0,0,0, 0,'hFFFF8001,0,NX,1);

    repeat (2) @(negedge clk);
    chk_reset(-1);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].vld, vq[i].op, vq[i].addr, vq[i].wdata, vq[i].gnt, vq[i].rv, vq[i].rdata);
      @(negedge clk);
      chk("ex_ready", i, 32'(ex_ready), 32'(vq[i].rdy));
      chk("mem_req", i, 32'(mem_req), 32'(vq[i].req));
      if (vq[i].req) begin
        chk("mem_we", i, 32'(mem_we), 32'(vq[i].we));
        chk("mem_addr", i, mem_addr, vq[i].maddr);
        chk("mem_be", i, 32'(mem_be), 32'(vq[i].be));
        if (vq[i].we) chk("mem_wdata", i, mem_wdata, vq[i].mwd);
      end
      chk("ld_valid", i, 32'(ld_valid), 32'(vq[i].ldv));
      chk("ld_data", i, ld_data, vq[i].ldd);
      chk("exp_valid", i, 32'(exp_valid), 32'(vq[i].expv));
      chk("exp_code", i, 32'(exp_code), 32'(vq[i].expc));
      chk("sb_empty", i, 32'(sb_empty), 32'(vq[i].empty));
    end

    // Reset while in LD_WAIT with two stores buffered; a late rvalid must be ignored.
    @(posedge clk); #1 drive(1'b1, MEM_OP_SW, 'h8000, 'h11, 1'b0, 1'b0, 0);
    @(posedge clk); #1 drive(1'b1, MEM_OP_SW, 'h8004, 'h22, 1'b0, 1'b0, 0);
    @(posedge clk); #1 drive(1'b1, MEM_OP_SW, 'h8008, 'h33, 1'b0, 1'b0, 0);
    @(posedge clk); #1 drive(1'b0, N, 0, 0, 1'b1, 1'b0, 0);
    @(posedge clk); #1 drive(1'b1, MEM_OP_LW, 'h9000, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("rs_ld_accept", 200, 32'(ex_ready), 32'h1);
    @(posedge clk); #1 drive(1'b0, N, 0, 0, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("rs_ld_req", 201, 32'(mem_req & ~mem_we), 32'h1);
    @(posedge clk); #1 drive(1'b0, N, 0, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("rs_wait_ready", 202, 32'(ex_ready), 32'h0);
    chk("rs_wait_req", 202, 32'(mem_req), 32'h0);
    chk("rs_wait_empty", 202, 32'(sb_empty), 32'h0);
    rst_n = 1'b0;
    #1 chk_reset(203);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 drive(1'b0, N, 0, 0, 1'b0, 1'b1, 'h12345678);
    @(posedge clk); #1 drive(1'b0, N, 0, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("rs_late_ld_valid", 204, 32'(ld_valid), 32'h0);
    chk("rs_late_ld_data", 204, ld_data, 32'h0);
    chk("rs_sb_empty", 204, 32'(sb_empty), 32'h1);
    chk("rs_mem_req", 204, 32'(mem_req), 32'h0);
    chk("rs_ex_ready", 204, 32'(ex_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_lsu_sb.md
Name: mem_lsu_sb

Overview:
- Parametrised successor to the MEM-stage memory controller.
- Accepts one load or store per cycle from EX and buffers stores in a SB_DEPTH-entry store buffer that drains to data memory over a req/gnt bus.
- Resolves store-to-load hazards by byte-granular forwarding from any buffered store, or by stalling when a store overlaps only partly.
- Performs byte-lane alignment and sign/zero extension, and raises misalignment exceptions.

Parameters:
- XLEN, 32, data/word width; must be 32 or 64.
- ADDR_W, 32, byte address width.
- SB_DEPTH, 4, store buffer entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_valid  in  1  EX presents a memory op
- ex_ready  out  1  op accepted this cycle; accept = ex_valid & ex_ready
- ex_mem_op  in  4  MEM_OP_* code (LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD/NONE)
- ex_addr  in  ADDR_W  effective byte address
- ex_wdata  in  XLEN  store data, LSB-justified
- ld_valid  out  1  one-cycle pulse: ld_data valid
- ld_data  out  XLEN  aligned, extended load result
- exp_valid  out  1  one-cycle exception pulse
- exp_code  out  DATA_WIDTH_ISA_EXP  ISA_EXP_LOAD_MISALIGNED / ISA_EXP_STORE_MISALIGNED
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (store-buffer drain), 0 = read
- mem_addr  out  ADDR_W  word-aligned address
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-positioned write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data returned
- mem_rdata  in  XLEN  full word of read data
- sb_empty  out  1  store buffer empty (used for fence/CSR drain)

Behaviour:
- Reset values: ex_ready=1, ld_valid=0, ld_data=0, exp_valid=0, exp_code=ISA_EXP_NO_EXP, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, sb_empty=1. Store-buffer count, head and tail pointers are 0; FSM is IDLE. Reset mid-transaction discards buffered stores and any outstanding read.
- Alignment: the access is aligned when addr mod size == 0. A misaligned op is accepted, causes no memory or buffer activity, and gives exp_valid=1 with the code in the next cycle.
- Store accept requires count<SB_DEPTH. No same-cycle enqueue-on-full bypass. The entry holds the word address, byte enables = size mask << offset, and data shifted to that lane.
- Drain:
  - Runs when FSM is IDLE, count>0, and no load is accepted this cycle.
  - Asserts mem_req/mem_we=1 with head-entry fields, all held stable until mem_gnt.
  - On mem_gnt: pop head, count decrements.
  - An enqueue and a pop in the same cycle leave count unchanged.
  - Once a drain req is raised, it has priority until granted.
- Load hazard check: compare the word address against all valid entries; resolve each required byte from the youngest matching entry.
  - All required bytes covered: forward, accept with no memory access; ld_valid and ld_data appear next cycle.
  - Some but not all bytes covered: ex_ready=0 while draining continues; re-evaluate each cycle.
  - No overlap: accept; FSM moves IDLE -> LD_REQ.
- Load FSM:
  - LD_REQ: mem_req=1, mem_we=0, mem_be=all 1s; on mem_gnt -> LD_WAIT.
  - LD_WAIT: on mem_rvalid, register the extracted, extended data; ld_valid pulses next cycle; -> IDLE.
  - ex_ready=0 in LD_REQ and LD_WAIT.
- Extraction: shift right by offset*8, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to XLEN. LD, SD and LWU exist only when XLEN=64; when XLEN=32 they are treated as MEM_OP_NONE.
- MEM_OP_NONE is accepted and produces no activity.
- sb_empty = (count==0), registered.

Decomposition:
- Shared package/define holds MEM_OP_* codes, ISA_EXP_* codes, DATA_WIDTH_ISA_EXP, and the size/byte-enable mask function.
- One sub-module, lsu_store_buffer: circular FIFO with head/tail/count and a parallel byte-granular youngest-match forward lookup. The top level holds the FSM, alignment logic and extension logic.

Test Plan:
- SW 0x1000 data 0xDEADBEEF, then LW 0x1000 next cycle -> forwarded; ld_valid 1 cycle after accept; ld_data=0xDEADBEEF; no mem read issued.
- SB 0x2001 data 0x80, then LB 0x2001 -> ld_data=0xFFFFFF80; LBU 0x2001 -> ld_data=0x00000080, both forwarded.
- SB 0x3000, then LW 0x3000 (partial overlap) -> ex_ready=0 until the drain is granted (mem_we=1, mem_be=0001); then a read is issued and ld_data equals the memory word.
- Fill SB_DEPTH=4 stores with mem_gnt=0 -> 5th store sees ex_ready=0. Raise mem_gnt for 1 cycle -> one pop, and the 5th store is accepted the next cycle with sb_empty=0.
- LH 0x4003 -> exp_valid=1 next cycle with exp_code=ISA_EXP_LOAD_MISALIGNED, no mem_req. SW 0x4002 -> ISA_EXP_STORE_MISALIGNED.
- Assert rst_n=0 in LD_WAIT with 2 buffered stores -> all outputs return to reset values, sb_empty=1, and a late mem_rvalid is ignored.
